ex_stage: RTL and testbench

Execute stage. It sits directly downstream of the ID/EX pipeline register and consumes that register's decoded operands and control fields. The block selects ALU operands (with optional forwarding), computes the ALU result, and resolves branches and jumps into a held redirect request. It also contains the EX/MEM pipeline register that feeds the memory stage.

---
 rtl/ex_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_ex_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, branch/jump redirect, EX/MEM register.
// Optional operand forwarding is enabled by defining EX_FWD_EN.
module ex_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          stall,
  input  logic [DW-1:0] pcIn,
  input  logic [DW-1:0] data1In,
  input  logic [DW-1:0] data2In,
  input  logic [DW-1:0] immIn,
  input  logic [RW-1:0] rxIn,
  input  logic [RW-1:0] ryIn,
  input  logic [RW-1:0] rzIn,
  input  logic [3:0]    aluOpIn,
  input  logic [1:0]    aluSrc1In,
  input  logic [1:0]    aluSrc2In,
  input  logic [1:0]    regDstIn,
  input  logic          branchIn,
  input  logic [1:0]    brCondIn,
  input  logic          jumpIn,
  input  logic          regWriteIn,
  input  logic          memtoRegIn,
  input  logic          rxToMemIn,
  input  logic [1:0]    memReadIn,
  input  logic [1:0]    memWriteIn,
  input  logic          wbRegWrite,
  input  logic [RW-1:0] wbDst,
  input  logic [DW-1:0] wbData,
  output logic [DW-1:0] aluResultOut,
  output logic [DW-1:0] memDataOut,
  output logic [RW-1:0] dstOut,
  output logic          regWriteOut,
  output logic          memtoRegOut,
  output logic [1:0]    memReadOut,
  output logic [1:0]    memWriteOut,
  output logic          redirect,
  output logic [DW-1:0] redirectPC
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_SLT = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_PSB = 4'd11;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [RW-1:0] dst;
    logic          rw;
    logic          m2r;
    logic [1:0]    mr;
    logic [1:0]    mw;
  } exmem_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  exmem_t        q;
  exmem_t        d;
  state_t        state;
  state_t        state_nx;
  logic [DW-1:0] tgt;
  logic [DW-1:0] tgt_nx;
  logic          flush;
  logic          cond;
  logic          take;
  logic [DW-1:0] fa;
  logic [DW-1:0] fb;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic [DW-1:0] res;
  logic [3:0]    sh;

`ifdef EX_FWD_EN
  // Forward register operands: own EX/MEM result first, then MEM/WB.
  always_comb begin
    fa = data1In;
    fb = data2In;
    if (q.rw && !q.m2r && q.dst == rxIn)
      fa = q.alu;
    else if (wbRegWrite && wbDst == rxIn)
      fa = wbData;
    if (q.rw && !q.m2r && q.dst == ryIn)
      fb = q.alu;
    else if (wbRegWrite && wbDst == ryIn)
      fb = wbData;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{wbRegWrite, wbDst, wbData};
  assign fa = data1In;
  assign fb = data2In;
`endif

  // Select ALU operands.
  always_comb begin
    opa = '0;
    opb = '0;
    case (aluSrc1In)
      2'd0:    opa = fa;
      2'd1:    opa = pcIn;
      default: opa = '0;
    endcase
    case (aluSrc2In)
      2'd0:    opb = fb;
      2'd1:    opb = immIn;
      2'd2:    opb = '0;
      default: opb = DW'(1);
    endcase
  end

  assign sh = opb[3:0];

  // ALU; all arithmetic wraps, no flags.
  always_comb begin
    res = '0;
    case (aluOpIn)
      OP_ADD:  res = opa + opb;
      OP_SUB:  res = opa - opb;
      OP_AND:  res = opa & opb;
      OP_OR:   res = opa | opb;
      OP_XOR:  res = opa ^ opb;
      OP_NOT:  res = ~opa;
      OP_SLL:  res = opa << sh;
      OP_SRL:  res = opa >> sh;
      OP_SRA:  res = $signed(opa) >>> sh;
      OP_SLT:  res = DW'($signed(opa) < $signed(opb));
      OP_CMP:  res = DW'(opa != opb);
      OP_PSB:  res = opb;
      default: res = '0;
    endcase
  end

  // Build the next EX/MEM contents from the current instruction.
  always_comb begin
    d     = '0;
    d.alu = res;
    d.mem = rxToMemIn ? fa : fb;
    d.m2r = memtoRegIn;
    d.mr  = memReadIn;
    d.mw  = memWriteIn;
    d.rw  = regWriteIn;
    case (regDstIn)
      2'd0: d.dst = rxIn;
      2'd1: d.dst = ryIn;
      2'd2: d.dst = rzIn;
      default: begin
        d.dst = '0;
        d.rw  = 1'b0;
      end
    endcase
  end

  // Branch condition tested on the (forwarded) A register value.
  always_comb begin
    cond = 1'b0;
    case (brCondIn)
      2'd0:    cond = 1'b1;
      2'd1:    cond = (fa == '0);
      2'd2:    cond = (fa != '0);
      default: cond = 1'b0;
    endcase
  end

  assign take = jumpIn | (branchIn & cond);

  // Redirect FSM next state; PEND flushes the instruction in EX.
  always_comb begin
    state_nx = state;
    tgt_nx   = tgt;
    flush    = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          state_nx = PEND;
          tgt_nx   = jumpIn ? fa : pcIn + immIn;
        end
      end
      PEND: begin
        flush = 1'b1;
        if (!stall)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Redirect FSM state and latched target.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      tgt   <= '0;
    end else begin
      state <= state_nx;
      tgt   <= tgt_nx;
    end
  end

  // EX/MEM register: hold on stall, bubble while a redirect is pending.
  always_ff @(posedge CLK) begin
    if (!RST)
      q <= '0;
    else if (!stall)
      q <= flush ? '0 : d;
  end

  assign aluResultOut = q.alu;
  assign memDataOut   = q.mem;
  assign dstOut       = q.dst;
  assign regWriteOut  = q.rw;
  assign memtoRegOut  = q.m2r;
  assign memReadOut   = q.mr;
  assign memWriteOut  = q.mw;
  assign redirect     = (state == PEND);
  assign redirectPC   = tgt;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed steps then random stimulus vs a model.
module tb_ex_stage;
  logic        CLK = 1'b0;
  logic        RST;
  logic        stall;
  logic [15:0] pcIn, data1In, data2In, immIn;
  logic [2:0]  rxIn, ryIn, rzIn;
  logic [3:0]  aluOpIn;
  logic [1:0]  aluSrc1In, aluSrc2In, regDstIn, brCondIn;
  logic        branchIn, jumpIn, regWriteIn, memtoRegIn, rxToMemIn;
  logic [1:0]  memReadIn, memWriteIn;
  logic        wbRegWrite;
  logic [2:0]  wbDst;
  logic [15:0] wbData;
  logic [15:0] aluResultOut, memDataOut, redirectPC;
  logic [2:0]  dstOut;
  logic        regWriteOut, memtoRegOut, redirect;
  logic [1:0]  memReadOut, memWriteOut;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] e_alu, e_mem, e_tgt;
  logic [2:0]  e_dst;
  logic        e_rw, e_m2r, e_pend;
  logic [1:0]  e_mr, e_mw;

  ex_stage dut (
    .CLK(CLK), .RST(RST), .stall(stall), .pcIn(pcIn),
    .data1In(data1In), .data2In(data2In), .immIn(immIn),
    .rxIn(rxIn), .ryIn(ryIn), .rzIn(rzIn), .aluOpIn(aluOpIn),
    .aluSrc1In(aluSrc1In), .aluSrc2In(aluSrc2In),
    .regDstIn(regDstIn), .branchIn(branchIn), .brCondIn(brCondIn),
    .jumpIn(jumpIn), .regWriteIn(regWriteIn),
    .memtoRegIn(memtoRegIn), .rxToMemIn(rxToMemIn),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn),
    .wbRegWrite(wbRegWrite), .wbDst(wbDst), .wbData(wbData),
    .aluResultOut(aluResultOut), .memDataOut(memDataOut),
    .dstOut(dstOut), .regWriteOut(regWriteOut),
    .memtoRegOut(memtoRegOut), .memReadOut(memReadOut),
    .memWriteOut(memWriteOut), .redirect(redirect),
    .redirectPC(redirectPC)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [3:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    int sh;
    int sa;
    int sb;
    sh = int'(b[3:0]);
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      4'd0:  return 16'(int'(a) + int'(b));
      4'd1:  return 16'(int'(a) - int'(b));
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a;
      4'd6:  return 16'(int'(a) * (1 << sh));
      4'd7:  return 16'(int'(a) / (1 << sh));
      4'd8:  return 16'($floor(real'(sa) / real'(1 << sh)));
      4'd9:  return (sa < sb) ? 16'd1 : 16'd0;
      4'd10: return (a == b) ? 16'd0 : 16'd1;
      4'd11: return b;
      default: return 16'd0;
    endcase
  endfunction

  task automatic clr_in();
    RST = 1'b1; stall = 1'b0;
    pcIn = '0; data1In = '0; data2In = '0; immIn = '0;
    rxIn = '0; ryIn = '0; rzIn = '0; aluOpIn = '0;
    aluSrc1In = '0; aluSrc2In = '0; regDstIn = '0; brCondIn = '0;
    branchIn = 0; jumpIn = 0; regWriteIn = 0; memtoRegIn = 0;
    rxToMemIn = 0; memReadIn = '0; memWriteIn = '0;
    wbRegWrite = 0; wbDst = '0; wbData = '0;
  endtask

  task automatic rand_in();
    stall = ($urandom_range(0, 3) == 0);
    pcIn = 16'($urandom); data1In = 16'($urandom);
    data2In = 16'($urandom); immIn = 16'($urandom);
    if ($urandom_range(0, 3) == 0) data1In = '0;
    rxIn = 3'($urandom); ryIn = 3'($urandom); rzIn = 3'($urandom);
    aluOpIn = 4'($urandom);
    aluSrc1In = 2'($urandom); aluSrc2In = 2'($urandom);
    regDstIn = 2'($urandom); brCondIn = 2'($urandom);
    branchIn = ($urandom_range(0, 3) == 0);
    jumpIn = ($urandom_range(0, 7) == 0);
    regWriteIn = 1'($urandom); memtoRegIn = 1'($urandom);
    rxToMemIn = 1'($urandom);
    memReadIn = 2'($urandom); memWriteIn = 2'($urandom);
    wbRegWrite = 1'($urandom); wbDst = 3'($urandom);
    wbData = 16'($urandom);
  endtask

  // One clock: predict from current inputs, clock, then compare.
  task automatic step();
    logic [15:0] fa, fb, a, b, n_alu, n_mem, n_tgt;
    logic [2:0]  n_dst;
    logic        n_rw, n_m2r, n_pend, c;
    logic [1:0]  n_mr, n_mw;
    n_alu = e_alu; n_mem = e_mem; n_dst = e_dst; n_rw = e_rw;
    n_m2r = e_m2r; n_mr = e_mr; n_mw = e_mw;
    n_pend = e_pend; n_tgt = e_tgt;
    if (!RST) begin
      n_alu = 0; n_mem = 0; n_dst = 0; n_rw = 0; n_m2r = 0;
      n_mr = 0; n_mw = 0; n_pend = 0; n_tgt = 0;
    end else begin
      fa = data1In;
      fb = data2In;
`ifdef EX_FWD_EN
      if (e_rw && !e_m2r && e_dst == rxIn) fa = e_alu;
      else if (wbRegWrite && wbDst == rxIn) fa = wbData;
      if (e_rw && !e_m2r && e_dst == ryIn) fb = e_alu;
      else if (wbRegWrite && wbDst == ryIn) fb = wbData;
`endif
      a = (aluSrc1In == 0) ? fa : (aluSrc1In == 1) ? pcIn : 16'd0;
      b = (aluSrc2In == 0) ? fb : (aluSrc2In == 1) ? immIn :
          (aluSrc2In == 2) ? 16'd0 : 16'd1;
      if (!stall) begin
        if (e_pend) begin
          n_alu = 0; n_mem = 0; n_dst = 0; n_rw = 0;
          n_m2r = 0; n_mr = 0; n_mw = 0;
        end else begin
          n_alu = ref_alu(aluOpIn, a, b);
          n_mem = rxToMemIn ? fa : fb;
          n_dst = (regDstIn == 0) ? rxIn : (regDstIn == 1) ? ryIn :
                  (regDstIn == 2) ? rzIn : 3'd0;
          n_rw = regWriteIn && (regDstIn != 3);
          n_m2r = memtoRegIn; n_mr = memReadIn; n_mw = memWriteIn;
        end
      end
      if (e_pend) begin
        if (!stall) n_pend = 0;
      end else begin
        c = (brCondIn == 0) || (brCondIn == 1 && fa == 0) ||
            (brCondIn == 2 && fa != 0);
        if (jumpIn || (branchIn && c)) begin
          n_pend = 1;
          n_tgt = jumpIn ? fa : 16'(int'(pcIn) + int'(immIn));
        end
      end
    end
    @(posedge CLK);
    #1;
    e_alu = n_alu; e_mem = n_mem; e_dst = n_dst; e_rw = n_rw;
    e_m2r = n_m2r; e_mr = n_mr; e_mw = n_mw;
    e_pend = n_pend; e_tgt = n_tgt;
    chk("alu", aluResultOut, e_alu);
    chk("mem", memDataOut, e_mem);
    chk("dst", 16'(dstOut), 16'(e_dst));
    chk("rw", 16'(regWriteOut), 16'(e_rw));
    chk("m2r", 16'(memtoRegOut), 16'(e_m2r));
    chk("mr", 16'(memReadOut), 16'(e_mr));
    chk("mw", 16'(memWriteOut), 16'(e_mw));
    chk("redir", 16'(redirect), 16'(e_pend));
    if (e_pend) chk("redir_pc", redirectPC, e_tgt);
  endtask

  initial begin
    e_alu = 0; e_mem = 0; e_dst = 0; e_rw = 0; e_m2r = 0;
    e_mr = 0; e_mw = 0; e_pend = 0; e_tgt = 0;

    // reset with random inputs
    rand_in(); RST = 1'b0; step();
    rand_in(); RST = 1'b0; step();
    chk("rst_alu", aluResultOut, 16'h0);
    chk("rst_redir", 16'(redirect), 16'h0);

    // ADD 7FFF + 1 into rz=5
    clr_in();
    data1In = 16'h7FFF; immIn = 16'h0001; aluSrc2In = 2'd1;
    regDstIn = 2'd2; rzIn = 3'd5; regWriteIn = 1'b1;
    step();
    chk("add_res", aluResultOut, 16'h8000);
    chk("add_dst", 16'(dstOut), 16'd5);
    chk("add_rw", 16'(regWriteOut), 16'd1);

    // SRA and SLT
    clr_in();
    rxIn = 3'd1; ryIn = 3'd2; regDstIn = 2'd2; rzIn = 3'd6;
    regWriteIn = 1'b1; aluOpIn = 4'd8;
    data1In = 16'h8000; data2In = 16'h0004;
    step();
    chk("sra", aluResultOut, 16'hF800);
    aluOpIn = 4'd9; data1In = 16'hFFFF; data2In = 16'h0001;
    step();
    chk("slt", aluResultOut, 16'h0001);

    // BEQZ taken while stalled
    clr_in();
    pcIn = 16'h0010; immIn = 16'hFFFE; branchIn = 1'b1;
    brCondIn = 2'd1; regWriteIn = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("beqz_redir", 16'(redirect), 16'd1);
      chk("beqz_pc", redirectPC, 16'h000E);
      chk("beqz_hold", aluResultOut, 16'h0001);
    end
    stall = 1'b0;
    step();
    chk("beqz_clr", 16'(redirect), 16'd0);
    chk("beqz_bub", 16'(regWriteOut), 16'd0);

    // back-to-back dependency through r3
    clr_in();
    aluSrc1In = 2'd2; aluSrc2In = 2'd1; immIn = 16'h1234;
    rxIn = 3'd3; regWriteIn = 1'b1;
    step();
    chk("fwd_i1", aluResultOut, 16'h1234);
    clr_in();
    rxIn = 3'd3; ryIn = 3'd3; regDstIn = 2'd2; rzIn = 3'd4;
    regWriteIn = 1'b1;
    step();
`ifdef EX_FWD_EN
    chk("fwd_i2", aluResultOut, 16'h2468);
`else
    chk("fwd_i2", aluResultOut, 16'h0000);
`endif

    // JR with branch also set
    clr_in();
    jumpIn = 1'b1; branchIn = 1'b1; brCondIn = 2'd0;
    pcIn = 16'h0100; immIn = 16'h0020; data1In = 16'h4000;
    rxIn = 3'd7;
    step();
    chk("jr_redir", 16'(redirect), 16'd1);
    chk("jr_pc", redirectPC, 16'h4000);
    clr_in();
    step();
    chk("jr_clr", 16'(redirect), 16'd0);

    // reset while a redirect is pending
    clr_in();
    jumpIn = 1'b1; data1In = 16'h00AA;
    step();
    RST = 1'b0; stall = 1'b1;
    step();
    chk("rst_pend", 16'(redirect), 16'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_in();
      RST = ($urandom_range(0, 40) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
